// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch path: memory geometry, reset PC,
// fetch FSM states and the fetch-buffer entry layout.
package riscv_pkg;

    localparam int INST_WIDTH             = 32;
    localparam int INST_MEM_ADD_BIT_WIDTH = 16;
    localparam int INST_BYTE_WIDTH        = 4;
    localparam logic [INST_MEM_ADD_BIT_WIDTH-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FULL,
        FAULT
    } fetch_state_e;

    typedef struct packed {
        logic [INST_MEM_ADD_BIT_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0]             inst;
    } fetch_entry_t;

    // inst_memory serves whole words and the half-word offset; anything else faults
    function automatic logic pc_aligned(input logic [INST_MEM_ADD_BIT_WIDTH-1:0] addr);
        logic [INST_MEM_ADD_BIT_WIDTH-1:0] offset;
        offset = addr % INST_MEM_ADD_BIT_WIDTH'(INST_BYTE_WIDTH);
        return (offset == '0) ||
               (offset == INST_MEM_ADD_BIT_WIDTH'(INST_BYTE_WIDTH / 2));
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} entries between instruction memory and decode.
// A synchronous flush empties it and overrides any push or pop in the same cycle.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head_entry,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    fetch_entry_t   mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    assign head_entry = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses inst_memory, buffers
// returned words and hands them to decode over valid/ready.
module inst_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int FETCH_BUF_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fetch_en,
    input  logic                              redirect_valid,
    input  logic [INST_MEM_ADD_BIT_WIDTH-1:0] redirect_pc,
    output logic [INST_MEM_ADD_BIT_WIDTH-1:0] inst_add,
    input  logic [INST_WIDTH-1:0]             inst_data,
    output logic                              if_valid,
    input  logic                              if_ready,
    output logic [INST_WIDTH-1:0]             if_inst,
    output logic [INST_MEM_ADD_BIT_WIDTH-1:0] if_pc,
    output logic                              fault,
    output logic [INST_MEM_ADD_BIT_WIDTH-1:0] fault_pc,
    input  logic                              fault_clr
);

    localparam logic [INST_MEM_ADD_BIT_WIDTH-1:0] PC_STEP =
        INST_MEM_ADD_BIT_WIDTH'(INST_BYTE_WIDTH);

    fetch_state_e                      state_q, state_d;
    logic [INST_MEM_ADD_BIT_WIDTH-1:0] pc_q, pc_d;
    logic                              fault_q, fault_d;
    logic [INST_MEM_ADD_BIT_WIDTH-1:0] fault_pc_q, fault_pc_d;

    logic         buf_push;
    logic         buf_pop;
    logic         buf_flush;
    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign push_entry = '{pc: pc_q, inst: inst_data};
    assign if_valid   = !buf_empty;
    assign buf_pop    = if_valid && if_ready;
    assign if_inst    = if_valid ? head_entry.inst : '0;
    assign if_pc      = if_valid ? head_entry.pc   : '0;
    assign inst_add   = pc_q;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

    fetch_buffer #(
        .DEPTH (FETCH_BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (buf_push),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    // FAULT is sticky and deaf to redirects; otherwise a redirect beats push/pop
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        buf_push   = 1'b0;
        buf_flush  = 1'b0;

        if (state_q == FAULT) begin
            buf_flush = 1'b1;
            if (fault_clr) begin
                state_d = IDLE;
                pc_d    = RESET_PC;
                fault_d = 1'b0;
            end
        end else if (redirect_valid) begin
            buf_flush = 1'b1;
            if (pc_aligned(redirect_pc)) begin
                pc_d    = redirect_pc;
                state_d = fetch_en ? FETCH : IDLE;
            end else begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (!buf_full || buf_pop) begin
                        buf_push = 1'b1;
                        pc_d     = pc_q + PC_STEP;
                    end
                    if (!fetch_en) begin
                        state_d = IDLE;
                    end else if (buf_full && !buf_pop) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (!fetch_en) begin
                        state_d = IDLE;
                    end else if (buf_pop) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a behavioural instruction memory
// plus an in-order scoreboard of expected fetch addresses for decode.
module tb_inst_fetch_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] inst_add;
    logic [31:0] inst_data;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_inst;
    logic [15:0] if_pc;
    logic        fault;
    logic [15:0] fault_pc;
    logic        fault_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;
    int p0;
    logic [15:0] sb[$];

    inst_fetch_ctrl #(
        .FETCH_BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_add       (inst_add),
        .inst_data      (inst_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fault_clr      (fault_clr)
    );

    always #5 clk = ~clk;

    // Each address returns a distinct word so a wrong pc/inst pairing shows up
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    assign inst_data = mem_word(inst_add);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_load(input logic [15:0] start, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) begin
            sb.push_back(start + 16'(4 * i));
        end
    endtask

    // Every accepted head is compared in order against the expected stream
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            logic [15:0] exp_pc;
            checks++;
            pop_count++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pop: got pc %h, required no delivery", if_pc);
            end else begin
                exp_pc = sb.pop_front();
                if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc)) begin
                    errors++;
                    $display("[TB] FAIL stream: got pc %h inst %h, required pc %h inst %h",
                             if_pc, if_inst, exp_pc, mem_word(exp_pc));
                end
            end
        end
    end

    task automatic apply_reset();
        fetch_en = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        fault_clr = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fetch_en = 1'b0;
        if_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (inst_add !== 16'h0 || if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_fetch: got add %h valid %b inst %h pc %h, required all zero",
                     inst_add, if_valid, if_inst, if_pc);
        end
        checks++;
        if (fault !== 1'b0 || fault_pc !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_fault: got fault %b fault_pc %h, required 0 0000", fault, fault_pc);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b0 || inst_add !== 16'h0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got valid %b add %h, required 0 0000", if_valid, inst_add);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        sb_load(16'h0, 40);
        fetch_en = 1'b1;
        if_ready = 1'b1;
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_latency: got valid %b, required 0", if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0) begin
            errors++;
            $display("[TB] FAIL first_valid: got valid %b pc %h, required 1 0000", if_valid, if_pc);
        end
        p0 = pop_count;
        repeat (10) tick();
        checks++;
        if (pop_count - p0 != 10) begin
            errors++;
            $display("[TB] FAIL throughput: got %0d pops, required 10", pop_count - p0);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_outside_fault: got fault %b, required 0", fault);
        end
        fetch_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain: got valid %b, required 0", if_valid);
        end
        fetch_en = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        sb_load(16'h0, 40);
        fetch_en = 1'b1;
        if_ready = 1'b0;
        for (int i = 0; i < 10 && !if_valid; i++) tick();
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_first_valid: got valid %b, required 1", if_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 16'h0 || if_inst !== mem_word(16'h0)) begin
                errors++;
                $display("[TB] FAIL stall_stable: got valid %b pc %h inst %h, required 1 0000 %h",
                         if_valid, if_pc, if_inst, mem_word(16'h0));
            end
        end
        checks++;
        if (inst_add !== 16'h0008) begin
            errors++;
            $display("[TB] FAIL full_pc_hold: got add %h, required 0008", inst_add);
        end
        if_ready = 1'b1;
        p0 = pop_count;
        repeat (12) tick();
        checks++;
        if (pop_count - p0 != 12) begin
            errors++;
            $display("[TB] FAIL resume: got %0d pops, required 12", pop_count - p0);
        end
    endtask

    task automatic test_redirect();
        if_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_redirect_valid: got %b, required 1", if_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        sb_load(16'h0040, 20);
        checks++;
        if (if_valid !== 1'b0 || inst_add !== 16'h0040) begin
            errors++;
            $display("[TB] FAIL redirect_flush: got valid %b add %h, required 0 0040", if_valid, inst_add);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_inst !== mem_word(16'h0040)) begin
            errors++;
            $display("[TB] FAIL redirect_target: got valid %b pc %h inst %h, required 1 0040 %h",
                     if_valid, if_pc, if_inst, mem_word(16'h0040));
        end
        repeat (5) tick();
    endtask

    task automatic test_halfword();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0042;
        tick();
        redirect_valid = 1'b0;
        sb_load(16'h0042, 20);
        checks++;
        if (inst_add !== 16'h0042 || fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL half_redirect: got add %h fault %b, required 0042 0", inst_add, fault);
        end
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0042) begin
            errors++;
            $display("[TB] FAIL half_first: got valid %b pc %h, required 1 0042", if_valid, if_pc);
        end
        repeat (4) tick();
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        tick();
        redirect_pc = 16'h0041;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        checks++;
        if (fault !== 1'b1 || fault_pc !== 16'h0041 || inst_add !== 16'h0080 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fault_entry: got fault %b fault_pc %h add %h valid %b, required 1 0041 0080 0",
                     fault, fault_pc, inst_add, if_valid);
        end
        for (int i = 0; i < 4; i++) begin
            redirect_valid = (i == 0);
            redirect_pc = 16'h0100;
            tick();
            checks++;
            if (fault !== 1'b1 || inst_add !== 16'h0080 || if_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fault_hold: got fault %b add %h valid %b, required 1 0080 0",
                         fault, inst_add, if_valid);
            end
        end
        redirect_valid = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        sb_load(16'h0, 20);
        checks++;
        if (fault !== 1'b0 || inst_add !== 16'h0) begin
            errors++;
            $display("[TB] FAIL fault_clear: got fault %b add %h, required 0 0000", fault, inst_add);
        end
        repeat (6) tick();
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_clear_fetch: got valid %b, required 1", if_valid);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFF8;
        tick();
        redirect_valid = 1'b0;
        sb_load(16'hFFF8, 12);
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'hFFF8) begin
            errors++;
            $display("[TB] FAIL wrap_first: got valid %b pc %h, required 1 fff8", if_valid, if_pc);
        end
        p0 = pop_count;
        repeat (6) tick();
        checks++;
        if (pop_count - p0 != 6 || fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_stream: got %0d pops fault %b, required 6 0", pop_count - p0, fault);
        end
    endtask

    task automatic test_async_reset();
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_valid: got %b, required 1", if_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || inst_add !== 16'h0 || fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid %b add %h fault %b, required 0 0000 0",
                     if_valid, inst_add, fault);
        end
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halfword();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
